// File: rtl/dmem_access_unit_pkg.sv
// Shared constants for the memory-stage data-access unit: word width,
// load/store funct3 codes, FSM state encodings and access-size decode.
package dmem_access_unit_pkg;

  localparam int WORD_SIZE = 32;

  // Load/store funct3 codes (stores reuse the signed load codes)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  // funct3[1:0] carries the size; the unlisted 011/110/111 fall to word.
  function automatic acc_size_e access_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// Request/grant/response bus between the access unit and data memory.
interface dmem_access_unit_if;
  import dmem_access_unit_pkg::*;

  logic                 memReq;
  logic                 memWe;
  logic [WORD_SIZE-1:0] memAddr;
  logic [WORD_SIZE-1:0] memWdata;
  logic [3:0]           memBe;
  logic                 memGnt;
  logic                 memRvalid;
  logic [WORD_SIZE-1:0] memRdata;

  modport master (
    output memReq, memWe, memAddr, memWdata, memBe,
    input  memGnt, memRvalid, memRdata
  );

  modport slave (
    input  memReq, memWe, memAddr, memWdata, memBe,
    output memGnt, memRvalid, memRdata
  );

endinterface

// File: rtl/dmem_access_unit_load_formatter.sv
// Combinational load formatter: picks the byte/half lane by offset and
// sign- or zero-extends it; word accesses pass straight through.
module dmem_access_unit_load_formatter
  import dmem_access_unit_pkg::*;
(
  input  logic [WORD_SIZE-1:0] rdata_i,
  input  logic [1:0]           offset_i,
  input  logic [2:0]           funct3_i,
  output logic [WORD_SIZE-1:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection followed by extension according to funct3.
  always_comb begin
    case (offset_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result_o = {24'd0, byte_sel};
      F3_LH:   result_o = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result_o = {16'd0, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Memory-stage data-access unit: accepts an aligned load/store from the
// EX/MEM register, runs the req/gnt/rvalid handshake and stalls the
// pipeline until done, then hands formatted load data to writeback.
//
// state | meaning
// IDLE  | waiting for an aligned access; misaligned ones fault here
// REQ   | memReq held with stable fields until memGnt
// WAIT  | load granted, waiting for memRvalid
// DONE  | access complete, stall released, readValidW pulses for loads
module dmem_access_unit
  import dmem_access_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 validM_i,
  input  logic                 memReadM_i,
  input  logic                 memWriteM_i,
  input  logic [2:0]           funct3M_i,
  input  logic [WORD_SIZE-1:0] aluOutM_i,
  input  logic [WORD_SIZE-1:0] writeDataM_i,
  output logic                 stallM_o,
  output logic                 misalignedM_o,
  output logic [WORD_SIZE-1:0] readDataW_o,
  output logic                 readValidW_o,
  dmem_access_unit_if.master   mem
);

  logic [1:0]           state_q, state_d;
  logic                 mem_req_q, mem_we_q;
  logic [WORD_SIZE-1:0] mem_addr_q, mem_wdata_q;
  logic [3:0]           mem_be_q;
  logic [2:0]           funct3_q;
  logic [1:0]           offset_q;
  logic [WORD_SIZE-1:0] read_data_q;
  logic                 read_valid_q;

  acc_size_e            size;
  logic                 access_req, misaligned, accept;
  logic [3:0]           be_d;
  logic [WORD_SIZE-1:0] wdata_d;
  logic [WORD_SIZE-1:0] load_fmt;

  // Lane steering and alignment check on the incoming M-stage access.
  always_comb begin
    size       = access_size(funct3M_i);
    access_req = validM_i && (memReadM_i || memWriteM_i);
    case (size)
      SZ_BYTE: begin
        be_d       = 4'b0001 << aluOutM_i[1:0];
        wdata_d    = {4{writeDataM_i[7:0]}};
        misaligned = 1'b0;
      end
      SZ_HALF: begin
        be_d       = aluOutM_i[1] ? 4'b1100 : 4'b0011;
        wdata_d    = {2{writeDataM_i[15:0]}};
        misaligned = aluOutM_i[0];
      end
      default: begin
        be_d       = 4'b1111;
        wdata_d    = writeDataM_i;
        misaligned = |aluOutM_i[1:0];
      end
    endcase
    accept        = (state_q == ST_IDLE) && access_req && !misaligned;
    misalignedM_o = (state_q == ST_IDLE) && access_req && misaligned;
    stallM_o      = accept || (state_q == ST_REQ) || (state_q == ST_WAIT);
  end

  // Next-state logic; stray gnt/rvalid outside REQ/WAIT fall through.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_REQ;
      ST_REQ:  if (mem.memGnt) state_d = mem_we_q ? ST_DONE : ST_WAIT;
      ST_WAIT: if (mem.memRvalid) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request fields and writeback registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= 4'b0000;
      funct3_q     <= 3'b000;
      offset_q     <= 2'b00;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      read_valid_q <= 1'b0;
      if (accept) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= !memReadM_i;
        mem_addr_q  <= {aluOutM_i[WORD_SIZE-1:2], 2'b00};
        mem_wdata_q <= wdata_d;
        mem_be_q    <= be_d;
        funct3_q    <= funct3M_i;
        offset_q    <= aluOutM_i[1:0];
      end else if (state_q == ST_REQ && mem.memGnt) begin
        mem_req_q <= 1'b0;
      end
      if (state_q == ST_WAIT && mem.memRvalid) begin
        read_data_q  <= load_fmt;
        read_valid_q <= 1'b1;
      end
    end
  end

  dmem_access_unit_load_formatter u_load_formatter (
    .rdata_i  (mem.memRdata),
    .offset_i (offset_q),
    .funct3_i (funct3_q),
    .result_o (load_fmt)
  );

  assign mem.memReq   = mem_req_q;
  assign mem.memWe    = mem_we_q;
  assign mem.memAddr  = mem_addr_q;
  assign mem.memWdata = mem_wdata_q;
  assign mem.memBe    = mem_be_q;
  assign readDataW_o  = read_data_q;
  assign readValidW_o = read_valid_q;

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Memory-stage data-access unit sitting directly downstream of the execute-stage ALU. It takes the ALU result as the effective address, plus store data and load/store control, from the EX/MEM register, and runs a request/grant/response handshake with data memory. It stalls the pipeline until the access completes, then delivers a sign- or zero-extended load result to writeback. It also performs byte-lane steering and alignment checking.

## Interface
- WORD_SIZE, 32, data and address width; only 32 is supported.

- clk  in  1  clock
- rst  in  1  reset
- validM  in  1  M-stage holds a valid instruction
- memReadM  in  1  instruction is a load
- memWriteM  in  1  instruction is a store
- funct3M  in  3  access size/sign (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- aluOutM  in  32  effective byte address (ALU output)
- writeDataM  in  32  store data, low-aligned
- stallM  out  1  hold IF..M stages
- misalignedM  out  1  alignment fault for current M instruction
- readDataW  out  32  formatted load data
- readValidW  out  1  one-cycle pulse: readDataW updated
- memReq  out  1  request valid
- memWe  out  1  1 = store
- memAddr  out  32  word address ({aluOutM[31:2],2'b00})
- memWdata  out  32  lane-replicated store data
- memBe  out  4  byte enables
- memGnt  in  1  memory accepts request this cycle
- memRvalid  in  1  load response valid
- memRdata  in  32  load response word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: the unit accepts an access when validM && (memReadM || memWriteM) && aligned.
  - It registers addr/we/be/wdata/funct3/byte offset and moves to REQ.
  - If both memReadM and memWriteM are set, the access is treated as a load.
- Alignment:
  - LH/LHU/SH fault if aluOutM[0] = 1.
  - LW/SW fault if aluOutM[1:0] ≠ 00.
  - A faulting access issues no request, produces no stall, and pulses misalignedM combinationally in IDLE. The FSM stays in IDLE.
- Unlisted funct3 (011, 110, 111) is treated as word access.
- REQ: memReq = 1 with all request fields stable until memGnt. On memGnt, a store goes to DONE and a load goes to WAIT.
- WAIT: memReq = 0. On memRvalid the unit captures memRdata, formats it, writes readDataW, and goes to DONE.
- DONE: stallM = 0 and readValidW = 1 (loads only). M-stage inputs are ignored this cycle. Next state is IDLE.
- Store lanes:
  - SB: be = 0001 << addr[1:0], wdata = {4{byte}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{half}}.
  - SW: be = 1111.
- Load formatting: select the byte or half lane by the stored offset. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- readDataW holds its value until the next load completes.
- memRvalid outside WAIT and memGnt outside REQ are ignored.

## Timing
- stallM is combinational and asserted:
  - in IDLE when an aligned access is accepted;
  - throughout REQ and WAIT;
  - deasserted in DONE.
- Minimum load (gnt in the first REQ cycle, rvalid in the next):
  - c0 accept, c1 REQ+gnt, c2 WAIT+rvalid, c3 DONE.
  - Stall covers c0–c2; readDataW/readValidW are valid in c3.
- Minimum store: c0 accept, c1 REQ+gnt, c2 DONE; stall covers c0–c1.
- Memory guarantees rvalid no earlier than one cycle after gnt.
- Wait states extend REQ or WAIT indefinitely; there is no timeout.
- Reset (asynchronous):
  - state = IDLE;
  - memReq, memWe, memAddr, memWdata, memBe, readDataW, readValidW = 0.
  - stallM and misalignedM evaluate to 0 with idle inputs.
- Reset mid-transaction abandons the access; a late memRvalid after reset is ignored.

## Structure
- The funct3 load/store codes and FSM state encodings go in the shared constants.v defines, alongside the ALU funct3 codes.
- Sub-module load_formatter is a combinational block: (rdata, offset[1:0], funct3) → 32-bit extended result. It is instantiated once.

## Test plan
- LW at 0x100, memRdata = 0xDEADBEEF, gnt in c1, rvalid in c2 → stallM high c0–c2, readValidW in c3, readDataW = 0xDEADBEEF, memAddr = 0x100.
- LB at 0x103 and LBU at 0x103, memRdata = 0x80FF_1234 → readDataW = 0xFFFFFF80, then 0x00000080.
- SH at 0x202, data 0x0000ABCD → memBe = 1100, memWdata = 0xABCDABCD, memWe = 1, stall covers 2 cycles.
- LW at 0x101 → misalignedM = 1 for one cycle, memReq never asserted, stallM = 0.
- Load with gnt delayed 3 cycles and rvalid delayed 2 → request fields stable throughout, stall held for the full duration, single readValidW pulse.
- rst asserted in WAIT, then memRvalid arrives → state IDLE, readValidW stays 0, all outputs at reset values.
